// File: rtl/axi2apb_bridge_ctrl.sv
// AXI4-Lite slave to APB4 master bridge: per-channel capture registers, alternating
// read/write arbitration, multi-slave decode with DECERR and an ACCESS-phase timeout.
module axi2apb_bridge_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLV_LSB    = 12,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [NUM_SLAVES-1:0]   psel,
  output logic                    penable,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic [1:0]              dbg_state
);
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3} state_t;

  state_t                r_state;
  logic                  r_live;
  logic                  r_aw_full, r_w_full, r_ar_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr, r_ar_addr;
  logic [2:0]            r_aw_prot, r_ar_prot;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;
  logic                  r_last_wr, r_is_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [2:0]            r_pprot;
  logic                  r_pwrite, r_penable;
  logic [DATA_WIDTH-1:0] r_pwdata, r_rdata;
  logic [STRB_W-1:0]     r_pstrb;
  logic [NUM_SLAVES-1:0] r_psel;
  logic                  r_bvalid, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;

  logic                  w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd, w_mapped;
  logic [ADDR_WIDTH-1:0] w_req_addr, w_slv_field;
  logic [SEL_W-1:0]      w_slv_idx;
  logic [NUM_SLAVES-1:0] w_sel_onehot;

  // Every AXI channel is valid/ready: a transfer happens on the clock edge where both
  // are high, and a raised valid keeps its payload stable until that edge.
  assign awready   = r_live & ~r_aw_full;
  assign wready    = r_live & ~r_w_full;
  assign arready   = r_live & ~r_ar_full;
  assign bvalid    = r_bvalid;
  assign bresp     = r_bresp;
  assign rvalid    = r_rvalid;
  assign rresp     = r_rresp;
  assign rdata     = r_rdata;
  assign paddr     = r_paddr;
  assign pprot     = r_pprot;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign dbg_state = r_state;

  // On a tie, the channel that did not win last time is served.
  assign w_wr_pend  = r_aw_full & r_w_full;
  assign w_rd_pend  = r_ar_full;
  assign w_grant_wr = w_wr_pend & (~w_rd_pend | ~r_last_wr);
  assign w_grant_rd = w_rd_pend & ~w_grant_wr;
  assign w_req_addr = w_grant_wr ? r_aw_addr : r_ar_addr;

  // Any address bit above the slave field being set also makes the access unmapped.
  assign w_slv_field = w_req_addr >> SLV_LSB;
  assign w_mapped    = (w_slv_field < ADDR_WIDTH'(NUM_SLAVES));
  assign w_slv_idx   = w_slv_field[SEL_W-1:0];

  always_comb begin
    w_sel_onehot = '0;
    w_sel_onehot[w_slv_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_live    <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_aw_addr <= '0;
      r_ar_addr <= '0;
      r_aw_prot <= '0;
      r_ar_prot <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_last_wr <= 1'b1;
      r_is_wr   <= 1'b0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pprot   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_live <= 1'b1;
      if (awvalid && awready) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= awaddr;
        r_aw_prot <= awprot;
      end
      if (wvalid && wready) begin
        r_w_full <= 1'b1;
        r_w_data <= wdata;
        r_w_strb <= wstrb;
      end
      if (arvalid && arready) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= araddr;
        r_ar_prot <= arprot;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant_wr || w_grant_rd) begin
            r_is_wr   <= w_grant_wr;
            r_last_wr <= w_grant_wr;
            if (w_grant_wr) begin
              r_aw_full <= 1'b0;
              r_w_full  <= 1'b0;
            end else begin
              r_ar_full <= 1'b0;
            end
            if (!w_mapped) begin
              r_state <= S_RESP;
              if (w_grant_wr) begin
                r_bvalid <= 1'b1;
                r_bresp  <= 2'b11;
              end else begin
                r_rvalid <= 1'b1;
                r_rresp  <= 2'b11;
                r_rdata  <= '0;
              end
            end else begin
              r_state  <= S_SETUP;
              r_psel   <= w_sel_onehot;
              r_paddr  <= w_req_addr;
              r_pprot  <= w_grant_wr ? r_aw_prot : r_ar_prot;
              r_pwrite <= w_grant_wr;
              r_pwdata <= w_grant_wr ? r_w_data : '0;
              r_pstrb  <= w_grant_wr ? r_w_strb : '0;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready || (TIMEOUT != 0 && r_cnt == CNT_W'(TIMEOUT - 1))) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= S_RESP;
            if (r_is_wr) begin
              r_bvalid <= 1'b1;
              r_bresp  <= (!pready || pslverr) ? 2'b10 : 2'b00;
            end else begin
              r_rvalid <= 1'b1;
              r_rresp  <= (!pready || pslverr) ? 2'b10 : 2'b00;
              r_rdata  <= pready ? prdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (r_bvalid && bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
          if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi2apb_bridge_ctrl.sv
// Directed bench for axi2apb_bridge_ctrl: table of single transfers plus hand-written
// sequences for arbitration, W-before-AW, timeout with a queued read, and mid-transfer reset.
module tb_axi2apb_bridge_ctrl;
  logic        clk, rst;
  logic [31:0] awaddr, araddr, wdata, rdata, paddr, pwdata, prdata;
  logic [2:0]  awprot, arprot, pprot;
  logic [3:0]  wstrb, pstrb, psel;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp, dbg_state;
  logic        pwrite, penable, pready, pslverr;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          slv_wait = 0;
  logic        slv_hang = 1'b0;
  logic        slv_err  = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;
  logic [32:0] apb_log[$];
  logic [32:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_st;
    logic        hang;
    logic        err;
    logic [31:0] prdat;
    int          hold;
    logic [3:0]  exp_psel;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  vec_t vecs[8];

  axi2apb_bridge_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(4), .SLV_LSB(12), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // APB slave model: pready after slv_wait wait states unless hung
  always @(posedge clk) begin
    if ((|psel) && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready  = (|psel) && penable && !slv_hang && (acc_cnt == slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  always @(posedge clk) begin
    if (rst && (|psel) && penable && pready) apb_log.push_back({pwrite, paddr});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks: each returns 1 time unit after its handshake edge
  task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
    int t = 0;
    awaddr = a; awprot = p; awvalid = 1'b1;
    while (!awready && t < 50) begin tick(); t++; end
    check("aw_accept", awready, 1'b1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && t < 50) begin tick(); t++; end
    check("w_accept", wready, 1'b1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
    int t = 0;
    araddr = a; arprot = p; arvalid = 1'b1;
    while (!arready && t < 50) begin tick(); t++; end
    check("ar_accept", arready, 1'b1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    if (v.wr) begin
      fork
        send_aw(v.addr, v.prot);
        send_w(v.data, v.strb);
      join
    end else begin
      send_ar(v.addr, v.prot);
    end
  endtask

  // Watches the APB phases and the response, starting in the cycle after the handshake.
  task automatic check_txn(input vec_t v);
    int          k = 1;
    int          setups = 0;
    int          accs = 0;
    logic        unstable = 1'b0;
    logic        hold_ok = 1'b1;
    logic [3:0]  seen_psel = '0;
    logic [31:0] c_addr = '0, c_wdata = '0, d0;
    logic [3:0]  c_strb = '0;
    logic [2:0]  c_prot = '0;
    logic        c_wr = 1'b0;
    logic [1:0]  r0;
    while (!(v.wr ? bvalid : rvalid) && k < 60) begin
      if (|psel) begin
        if (!penable) begin
          setups++;
          seen_psel = psel; c_addr = paddr; c_wdata = pwdata;
          c_strb = pstrb; c_prot = pprot; c_wr = pwrite;
        end else begin
          accs++;
          if (psel !== seen_psel || paddr !== c_addr || pwdata !== c_wdata ||
              pstrb !== c_strb || pprot !== c_prot || pwrite !== c_wr) unstable = 1'b1;
        end
      end
      tick();
      k++;
    end
    check("valid_seen", v.wr ? bvalid : rvalid, 1'b1);
    check("other_valid_low", v.wr ? rvalid : bvalid, 1'b0);
    if (v.exp_lat > 0) check("latency", k, v.exp_lat);
    check("psel_onehot", seen_psel, v.exp_psel);
    check("access_cycles", accs, v.exp_acc);
    if (v.exp_psel != 0) begin
      check("setup_cycles", setups, 1);
      check("apb_stable", unstable, 1'b0);
      check("paddr", c_addr, v.addr);
      check("pwrite", c_wr, v.wr);
      check("pstrb", c_strb, v.wr ? v.strb : 4'h0);
      check("pprot", c_prot, v.prot);
      if (v.wr) check("pwdata", c_wdata, v.data);
    end
    check("apb_idle_at_resp", {psel, penable}, 5'b0);
    check("resp", v.wr ? bresp : rresp, v.exp_resp);
    if (!v.wr) check("rdata", rdata, v.exp_rdata);
    r0 = v.wr ? bresp : rresp;
    d0 = rdata;
    for (int h = 0; h < v.hold; h++) begin
      tick();
      if (!(v.wr ? bvalid : rvalid) || (v.wr ? bresp : rresp) !== r0 || (!v.wr && rdata !== d0))
        hold_ok = 1'b0;
    end
    if (v.hold > 0) check("hold_stable", hold_ok, 1'b1);
    if (v.wr) bready = 1'b1; else rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("valid_dropped", v.wr ? bvalid : rvalid, 1'b0);
  endtask

  initial begin
    vec_t w_late, t_wr, t_rd;
    logic bad;
    // fields: wr, addr, data, strb, prot, wait, hang, err, prdata, hold,
    //         exp_psel, exp_resp, exp_rdata, exp_lat, exp_acc
    vecs[0] = '{1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 1'b0, 32'h0, 0,
                4'b0010, 2'b00, 32'h0, 4, 1};
    vecs[1] = '{1'b0, 32'h0000_3004, 32'h0, 4'h0, 3'b001, 3, 1'b0, 1'b1, 32'h1234_5678, 5,
                4'b1000, 2'b10, 32'h1234_5678, 7, 4};
    vecs[2] = '{1'b1, 32'h0000_5000, 32'h1111_1111, 4'hF, 3'b000, 0, 1'b0, 1'b0, 32'h0, 0,
                4'b0000, 2'b11, 32'h0, 2, 0};
    vecs[3] = '{1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0,
                4'b0000, 2'b11, 32'h0, 2, 0};
    vecs[4] = '{1'b1, 32'h0000_0004, 32'h0000_A5A5, 4'h3, 3'b010, 1, 1'b0, 1'b0, 32'h0, 2,
                4'b0001, 2'b00, 32'h0, 5, 2};
    vecs[5] = '{1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b100, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 0,
                4'b0100, 2'b00, 32'hCAFE_F00D, 4, 1};
    vecs[6] = '{1'b1, 32'h0000_3FFC, 32'h0123_4567, 4'h8, 3'b000, 2, 1'b0, 1'b1, 32'h0, 3,
                4'b1000, 2'b10, 32'h0, 6, 3};
    vecs[7] = '{1'b0, 32'h0001_0000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 32'h5555_5555, 0,
                4'b0000, 2'b11, 32'h0, 2, 0};

    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_apb_ctl", {psel, penable, pwrite}, 6'b0);
    check("rst_resp", {bresp, rresp}, 4'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_paddr_pwdata", {paddr, pwdata}, 64'h0);
    check("rst_pstrb_pprot", {pstrb, pprot}, 7'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b1;
    tick();
    check("ready_after_rst", {awready, wready, arready}, 3'b111);

    // tie after reset goes to read; re-issued requests then alternate
    apb_log.delete();
    exp_q.push_back({1'b0, 32'h0000_2000});
    exp_q.push_back({1'b1, 32'h0000_1000});
    exp_q.push_back({1'b0, 32'h0000_2100});
    exp_q.push_back({1'b1, 32'h0000_1100});
    slv_wait = 0; slv_err = 0; slv_rdata = 32'h0;
    bready = 1'b1; rready = 1'b1;
    fork
      begin
        send_ar(32'h0000_2000, 3'b000);
        send_ar(32'h0000_2100, 3'b000);
      end
      begin
        fork
          send_aw(32'h0000_1000, 3'b000);
          send_w(32'h0000_0001, 4'hF);
        join
        fork
          send_aw(32'h0000_1100, 3'b000);
          send_w(32'h0000_0002, 4'hF);
        join
      end
    join
    for (int t = 0; t < 100 && apb_log.size() < 4; t++) tick();
    check("arb_count", apb_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (apb_log.size() > 0) check("arb_order", apb_log.pop_front(), exp_q.pop_front());
    end
    repeat (3) tick();
    check("arb_drained", {dbg_state, bvalid, rvalid}, 4'b0);
    bready = 1'b0; rready = 1'b0;

    foreach (vecs[i]) begin
      slv_wait = vecs[i].wait_st; slv_hang = vecs[i].hang;
      slv_err = vecs[i].err; slv_rdata = vecs[i].prdat;
      issue(vecs[i]);
      check_txn(vecs[i]);
    end

    // W two cycles before AW
    w_late = '{1'b1, 32'h0000_2010, 32'h600D_F00D, 4'h6, 3'b001, 0, 1'b0, 1'b0, 32'h0, 0,
               4'b0100, 2'b00, 32'h0, 4, 1};
    slv_wait = 0; slv_hang = 0; slv_err = 0;
    send_w(w_late.data, w_late.strb);
    bad = 1'b0;
    if ((|psel) || dbg_state != 2'd0) bad = 1'b1;
    tick();
    if ((|psel) || dbg_state != 2'd0) bad = 1'b1;
    check("no_apb_before_aw", bad, 1'b0);
    send_aw(w_late.addr, w_late.prot);
    check_txn(w_late);

    // hung slave: 8 ACCESS cycles then SLVERR, queued read proceeds normally
    t_wr = '{1'b1, 32'h0000_0100, 32'hAAAA_5555, 4'hF, 3'b000, 0, 1'b1, 1'b0, 32'h0, 0,
             4'b0001, 2'b10, 32'h0, 10, 8};
    t_rd = '{1'b0, 32'h0000_2040, 32'h0, 4'h0, 3'b011, 0, 1'b0, 1'b0, 32'h0BAD_CAFE, 0,
             4'b0100, 2'b00, 32'h0BAD_CAFE, 4, 1};
    slv_hang = 1'b1; slv_rdata = 32'h0BAD_CAFE;
    issue(t_wr);
    send_ar(t_rd.addr, t_rd.prot);
    check_txn(t_wr);
    slv_hang = 1'b0;
    check_txn(t_rd);

    // reset in the middle of an ACCESS with a read queued behind it
    slv_hang = 1'b1;
    fork
      send_aw(32'h0000_0200, 3'b000);
      send_w(32'h1, 4'hF);
    join
    send_ar(32'h0000_2000, 3'b000);
    tick();
    check("mid_in_access", {dbg_state, penable}, 3'b101);
    rst = 1'b0;
    #1;
    check("mid_rst_apb", {psel, penable}, 5'b0);
    check("mid_rst_valid_ready", {bvalid, rvalid, awready, wready, arready}, 5'b0);
    tick();
    rst = 1'b1;
    slv_hang = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if ((|psel) || bvalid || rvalid || dbg_state != 2'd0) bad = 1'b1;
    end
    check("mid_queue_discarded", bad, 1'b0);
    slv_wait = vecs[5].wait_st; slv_err = vecs[5].err; slv_rdata = vecs[5].prdat;
    issue(vecs[5]);
    check_txn(vecs[5]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi2apb_bridge_ctrl.md
# axi2apb_bridge_ctrl

Parametrised AXI4-Lite slave to APB4 master bridge controller with a complete APB setup/access state machine, independent AW/W/AR capture registers, read/write arbitration, multi-slave address decode and an access timeout. It sits between the AXI4-Lite interconnect port and the APB peripheral segment and replaces the single-slave converter. It adds full B/R response generation, DECERR on unmapped addresses, and SLVERR on timeout.

## Interface
- DATA_WIDTH, 32: AXI/APB data width; must be 32 or 64.
- ADDR_WIDTH, 32: address width.
- NUM_SLAVES, 4: APB slave count, 1..16; SEL_W = max(1, clog2(NUM_SLAVES)).
- SLV_LSB, 12: lowest address bit of the slave index field addr[SLV_LSB +: SEL_W].
- TIMEOUT, 256: maximum ACCESS cycles before abort; 0 disables the timeout.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-low.
- awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  AXI write address channel.
- wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI write data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  AXI write response.
- araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  AXI read address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  AXI read data channel.
- paddr/pprot/pwrite/pwdata/pstrb  out  ADDR_WIDTH/3/1/DATA_WIDTH/DATA_WIDTH/8  APB request fields.
- psel  out  NUM_SLAVES  one-hot APB slave select.
- penable  out  1  APB access phase.
- prdata/pready/pslverr  in  DATA_WIDTH/1/1  response of the currently selected slave, muxed by the APB segment.

## Operation
- Capture registers: one each for AW, W and AR, each holding a valid flag. awready = ~aw_full, wready = ~w_full, arready = ~ar_full. A handshake (valid & ready) loads the register. The flag clears when the grant is taken in IDLE.
- Write pending = aw_full & w_full. AW and W are accepted in any order or in the same cycle. Read pending = ar_full.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: if exactly one request is pending, grant it. If both are pending, grant the one not granted last. last_grant resets to write, so the first tie goes to read.
  - Decoded index >= NUM_SLAVES: go directly to RESP with DECERR (2'b11), rdata = 0, and no APB activity.
  - Otherwise: latch the APB fields and go to SETUP.
- SETUP: psel[index] = 1, penable = 0. Always goes to ACCESS next cycle.
- ACCESS: psel[index] = 1, penable = 1.
  - pready = 1: latch the response (pslverr → 2'b10, else 2'b00) and, for a read, prdata into rdata. Go to RESP.
  - TIMEOUT ≠ 0 and the access counter reaches TIMEOUT with no pready: abort with SLVERR (2'b10), rdata = 0. Go to RESP.
- RESP: assert bvalid (write) or rvalid (read) with the latched resp/data. On bready/rready handshake, drop valid and return to IDLE.
- APB request fields stay stable from SETUP through the last ACCESS cycle. pstrb = wstrb for writes and all-zero for reads. pprot = awprot or arprot of the granted request.
- Capture registers keep accepting new requests during SETUP, ACCESS and RESP, so one request per channel can be queued behind the active one.

## Timing
- Reset (rst low): awready, wready, arready, bvalid, rvalid, psel, penable and pwrite are 0; bresp, rresp, rdata, paddr, pwdata, pstrb and pprot are 0; state = IDLE; capture flags cleared; counter = 0.
- Ready outputs rise in the first cycle after rst deasserts.
- Request granted in IDLE at cycle N:
  - SETUP at N+1, ACCESS at N+2.
  - Zero-wait slave (pready at N+2): valid asserted at N+3.
  - Each slave wait state adds one cycle.
- DECERR request granted at N: valid asserted at N+1.
- AXI handshake at cycle H: the request is visible in IDLE at H+1. Minimum AXI-to-response latency is 4 cycles.
- Timeout counter clears on entering ACCESS and increments each ACCESS cycle without pready. Abort occurs in the ACCESS cycle where count = TIMEOUT−1, so there are exactly TIMEOUT ACCESS cycles; psel and penable drop the next cycle.
- bvalid/rvalid are held, with stable resp/data, until the ready handshake; backpressure of any length is tolerated.
- Reset mid-transfer immediately clears psel, penable and valids; queued requests are discarded.

## Test plan
- Single write, AW and W in the same cycle, addr 0x0000_1010, data 0xDEADBEEF, strb 0xF, pready in the first ACCESS cycle → psel = 4'b0010, pwdata = 0xDEADBEEF, bvalid 4 cycles after the handshake, bresp = 00.
- W two cycles before AW → no APB activity until AW is captured; the transfer then completes with the correct pwdata and pstrb.
- Read from addr 0x0000_3004, slave asserts pready after 3 wait states with prdata 0x12345678, pslverr = 1 → rdata = 0x12345678, rresp = 10, rvalid held 5 cycles under rready = 0.
- Read and write pending simultaneously after reset → read served first; with both re-issued, the write is served next (alternation).
- Addr 0x0000_5000 with NUM_SLAVES = 4 → no psel, DECERR (11) one cycle after grant.
- TIMEOUT = 8, slave never asserts pready → exactly 8 ACCESS cycles, then bresp = 10; the next queued transfer proceeds normally.
